// File: rtl/cmp_arbiter_pkg.sv
// cmp_arbiter_pkg: shared definitions for the comparator arbiter.
//   - CMP_EQ / CMP_GT / CMP_LT : 2-bit result codes returned to requesters
//   - state_t                  : arbiter FSM states (IDLE -> GRANT -> CMP)
//   - rr_next_ptr              : round-robin pointer advance with wrap
// Build option: CMP_ARB_SIGNED_EN (see cmp_unit) does not change anything here.
package cmp_arbiter_pkg;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CMP   = 2'd2
    } state_t;

    // Advance a requester index by one, wrapping from n-1 back to 0.
    // Index and n are carried as 8-bit values so callers of any width can use it.
    function automatic logic [7:0] rr_next_ptr(input logic [7:0] idx, input logic [7:0] n);
        logic [7:0] nxt;
        if (idx == n - 8'd1) begin
            nxt = 8'd0;
        end else begin
            nxt = idx + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cmp_arbiter_cmp_unit.sv
// cmp_unit: purely combinational WIDTH-bit magnitude comparator.
// Ports:
//   a, b  in  WIDTH  operands
//   res   out 2      CMP_EQ (a==b), CMP_GT (a>b), CMP_LT (a<b); 2'b11 never produced
// Build option: CMP_ARB_SIGNED_EN defined -> operands treated as two's complement
//   (MSB is the sign bit); undefined -> unsigned compare over all WIDTH bits.
module cmp_unit
    import cmp_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       res
);

    logic gt;
    logic lt;

`ifdef CMP_ARB_SIGNED_EN
    assign gt = $signed(a) > $signed(b);
    assign lt = $signed(a) < $signed(b);
`else
    assign gt = a > b;
    assign lt = a < b;
`endif

    always_comb begin
        res = CMP_EQ;
        if (gt) begin
            res = CMP_GT;
        end else if (lt) begin
            res = CMP_LT;
        end
    end

endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one cmp_unit among N_REQ requesters with round-robin
// arbitration. A winner's operands are latched when leaving IDLE, compared in
// GRANT, and the result is returned with a one-cycle one-hot ack while in CMP.
// Ports:
//   clk      in   1            system clock (rising edge)
//   reset    in   1            asynchronous, active-high
//   req      in   N_REQ        level request per requester, held until ack
//   a_bus    in   N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   b_bus    in   N_REQ*WIDTH  operand B, same packing
//   ack      out  N_REQ        one-hot one-cycle pulse for the served requester
//   rsp_res  out  2            00 equal, 01 A>B, 10 A<B
//   rsp_id   out  IDW          index of the served requester
//   busy     out  1            high whenever the FSM is not in IDLE
// Build option: CMP_ARB_SIGNED_EN selects a signed compare inside cmp_unit;
//   timing and encoding are identical either way.
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_bus,
    input  logic [N_REQ*WIDTH-1:0] b_bus,
    output logic [N_REQ-1:0]       ack,
    output logic [1:0]             rsp_res,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy
);

    localparam logic [IDW:0] N_REQ_W = (IDW + 1)'(N_REQ);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_reg,   state_next;
    logic [IDW-1:0]     rr_ptr_reg,  rr_ptr_next;
    logic [WIDTH-1:0]   a_op_reg,    a_op_next;
    logic [WIDTH-1:0]   b_op_reg,    b_op_next;
    logic [IDW-1:0]     id_reg,      id_next;
    logic [N_REQ-1:0]   ack_reg,     ack_next;
    logic [1:0]         rsp_res_reg, rsp_res_next;
    logic [IDW-1:0]     rsp_id_reg,  rsp_id_next;

    // ------------------------------------------------------------------
    // Operand unpacking and request rotation
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_arr   [N_REQ];
    logic [WIDTH-1:0] b_arr   [N_REQ];
    logic [N_REQ-1:0] req_rot;
    logic [IDW-1:0]   idx_rot [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = a_bus[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = b_bus[gi*WIDTH +: WIDTH];
        end

        // req_rot[k] is the request of requester (rr_ptr + k) mod N_REQ, so the
        // lowest set bit of req_rot is the round-robin winner. rr_ptr is always
        // below N_REQ, hence a single conditional subtract performs the wrap.
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [IDW:0] sum;
            assign sum = {1'b0, rr_ptr_reg} + (IDW + 1)'(gi);
            assign idx_rot[gi] = (sum >= N_REQ_W) ? IDW'(sum - N_REQ_W) : sum[IDW-1:0];
            assign req_rot[gi] = req[idx_rot[gi]];
        end
    endgenerate

    logic           win_hit;
    logic [IDW-1:0] win_id;

    // Scan from the far end down so the lowest rotated position wins.
    always_comb begin
        win_hit = 1'b0;
        win_id  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_hit = 1'b1;
                win_id  = idx_rot[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared comparator, fed only from the latched operand registers
    // ------------------------------------------------------------------
    logic [1:0] cmp_res;

    cmp_unit #(
        .WIDTH (WIDTH)
    ) u_cmp_unit (
        .a   (a_op_reg),
        .b   (b_op_reg),
        .res (cmp_res)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            rr_ptr_reg  <= '0;
            a_op_reg    <= '0;
            b_op_reg    <= '0;
            id_reg      <= '0;
            ack_reg     <= '0;
            rsp_res_reg <= CMP_EQ;
            rsp_id_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            a_op_reg    <= a_op_next;
            b_op_reg    <= b_op_next;
            id_reg      <= id_next;
            ack_reg     <= ack_next;
            rsp_res_reg <= rsp_res_next;
            rsp_id_reg  <= rsp_id_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath loads
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        a_op_next    = a_op_reg;
        b_op_next    = b_op_reg;
        id_next      = id_reg;
        ack_next     = '0;          // ack is a pulse: cleared unless loaded below
        rsp_res_next = rsp_res_reg; // response fields hold their last value
        rsp_id_next  = rsp_id_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (win_hit) begin
                    a_op_next  = a_arr[win_id];
                    b_op_next  = b_arr[win_id];
                    id_next    = win_id;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Result is captured on the edge into CMP so that ack, rsp_res
                // and rsp_id are all registered and visible throughout CMP.
                rsp_res_next = cmp_res;
                rsp_id_next  = id_reg;
                ack_next     = N_REQ'(1) << id_reg;
                state_next   = ST_CMP;
            end
            ST_CMP: begin
                rr_ptr_next = IDW'(rr_next_ptr(8'(id_reg), 8'(N_REQ)));
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ack     = ack_reg;
    assign rsp_res = rsp_res_reg;
    assign rsp_id  = rsp_id_reg;
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed self-checking bench for cmp_arbiter.
// A transaction-level model (grant search by modular arithmetic, integer compare,
// fixed two-cycle response delay) is compared against the DUT every cycle, and
// literal expectations pin latency, ids and result codes of each scenario.
module tb_cmp_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                   clk   = 1'b0;
    logic                   reset = 1'b1;
    logic [N_REQ-1:0]       req   = '0;
    logic [N_REQ*WIDTH-1:0] a_bus = '0;
    logic [N_REQ*WIDTH-1:0] b_bus = '0;
    logic [N_REQ-1:0]       ack;
    logic [1:0]             rsp_res;
    logic [IDW-1:0]         rsp_id;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmp_arbiter #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .a_bus   (a_bus),
        .b_bus   (b_bus),
        .ack     (ack),
        .rsp_res (rsp_res),
        .rsp_id  (rsp_id),
        .busy    (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [1:0] model_cmp(input int a, input int b);
        int sa;
        int sb;
        sa = a;
        sb = b;
`ifdef CMP_ARB_SIGNED_EN
        if (sa >= 2 ** (WIDTH - 1)) sa = sa - 2 ** WIDTH;
        if (sb >= 2 ** (WIDTH - 1)) sb = sb - 2 ** WIDTH;
`endif
        if (sa > sb) return 2'b01;
        if (sa < sb) return 2'b10;
        return 2'b00;
    endfunction

    int               m_left;      // cycles until the arbiter is free again
    int               m_ptr;       // first requester to consider next
    int               m_pend_id;
    logic [1:0]       m_pend_res;
    logic [N_REQ-1:0] m_ack;
    logic [1:0]       m_res;
    int               m_id;
    int               m_w;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_ptr  <= 0;
            m_ack  <= '0;
            m_res  <= 2'b00;
            m_id   <= 0;
        end else if (m_left == 0) begin
            m_ack <= '0;
            m_w = -1;
            for (int k = 0; k < N_REQ; k++) begin
                if (m_w < 0 && req[(m_ptr + k) % N_REQ]) m_w = (m_ptr + k) % N_REQ;
            end
            if (m_w >= 0) begin
                m_pend_id  <= m_w;
                m_pend_res <= model_cmp(int'(a_bus[m_w*WIDTH +: WIDTH]),
                                        int'(b_bus[m_w*WIDTH +: WIDTH]));
                m_left     <= 2;
            end
        end else if (m_left == 2) begin
            m_ack  <= N_REQ'(1) << m_pend_id;
            m_res  <= m_pend_res;
            m_id   <= m_pend_id;
            m_left <= 1;
        end else begin
            m_ack  <= '0;
            m_ptr  <= (m_pend_id + 1) % N_REQ;
            m_left <= 0;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        #1;
        chk("ack",     int'(ack),     int'(m_ack));
        chk("busy",    int'(busy),    int'(m_left != 0));
        chk("rsp_res", int'(rsp_res), int'(m_res));
        chk("rsp_id",  int'(rsp_id),  m_id);
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic wait_ack(output int id, output int lat);
        id  = -1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                lat = i;
                for (int k = 0; k < N_REQ; k++) if (ack[k]) id = k;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL wait_ack: no ack within 10 cycles at %0t", $time);
        end
    endtask

    task automatic wait_idle();
        int seen;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1;
                break;
            end
        end
        if (seen == 0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: still busy after 10 cycles at %0t", $time);
        end
    endtask

    task automatic txn(input string name, input int id, input int lat,
                       input int exp_id, input int exp_lat, input int exp_res);
        $display("txn %-10s id=%0d lat=%0d res=%0d", name, id, lat, rsp_res);
        chk({name, "_id"},  id,           exp_id);
        chk({name, "_lat"}, lat,          exp_lat);
        chk({name, "_res"}, int'(rsp_res), exp_res);
        chk({name, "_rid"}, int'(rsp_id), exp_id);
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    int id;
    int lat;
    int fair_ids [5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset with all requests pending: nothing may respond.
        req   = 4'b1111;
        a_bus = 16'h72B4;   // a3=7 a2=2 a1=11 a0=4
        b_bus = 16'hD936;   // b3=13 b2=9 b1=3 b0=6
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack",  int'(ack),     0);
            chk("rst_busy", int'(busy),    0);
            chk("rst_res",  int'(rsp_res), 0);
        end
        reset = 1'b0;

        // Fairness: first ack to id 0 two cycles after release, then every 3.
        wait_ack(id, lat);
        txn("fair0", id, lat, 0, 2, 2);
        for (int n = 1; n < 5; n++) begin
            wait_ack(id, lat);
            $display("txn fair%0d id=%0d lat=%0d", n, id, lat);
            chk("fair_id",  id,  fair_ids[n]);
            chk("fair_lat", lat, 3);
        end
        req = '0;

        // Single request; operand change during GRANT must be ignored.
        wait_idle();
        a_bus = '0;
        b_bus = '0;
        a_bus[3:0] = 4'd9;
        b_bus[3:0] = 4'd3;
        req = 4'b0001;
        @(negedge clk);
        chk("single_busy", int'(busy), 1);
        a_bus[3:0] = 4'd0;
        wait_ack(id, lat);
        txn("single", id, lat + 1, 0, 2, 1);
        req = '0;

        // Equal, then less, on requester 2.
        wait_idle();
        a_bus[11:8] = 4'd5;
        b_bus[11:8] = 4'd5;
        req = 4'b0100;
        wait_ack(id, lat);
        txn("equal", id, lat, 2, 2, 0);
        req = '0;
        wait_idle();
        a_bus[11:8] = 4'd2;
        b_bus[11:8] = 4'd12;
        req = 4'b0100;
        wait_ack(id, lat);
        txn("less", id, lat, 2, 2, 2);
        req = '0;

        // Requester drops before ack: compare still completes.
        wait_idle();
        a_bus[7:4] = 4'd15;
        b_bus[7:4] = 4'd14;
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        wait_ack(id, lat);
        txn("drop", id, lat + 1, 1, 2, 1);

        // Reset while a compare is in flight: no ack, pointer back to 0.
        wait_idle();
        req = 4'b0100;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_ack",  int'(ack),  0);
        reset = 1'b1;
        req   = '0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_hold_ack", int'(ack), 0);
        end
        reset = 1'b0;
        a_bus[15:12] = 4'd3;
        b_bus[15:12] = 4'd3;
        req = 4'b1010;
        wait_ack(id, lat);
        txn("postrst", id, lat, 1, 2, 1);
        req = '0;

        // Non-winner request raised during GRANT stays pending.
        wait_idle();
        a_bus[3:0] = 4'd1;
        b_bus[3:0] = 4'd1;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b1001;
        wait_ack(id, lat);
        txn("pend0", id, lat + 1, 0, 2, 0);
        req = 4'b1000;
        wait_ack(id, lat);
        txn("pend3", id, lat, 3, 3, 0);
        req = '0;

        // MSB-set operand: sign interpretation depends on the build.
        wait_idle();
        a_bus[3:0] = 4'b1000;
        b_bus[3:0] = 4'b0001;
        req = 4'b0001;
        wait_ack(id, lat);
`ifdef CMP_ARB_SIGNED_EN
        txn("msb", id, lat, 0, 2, 2);
`else
        txn("msb", id, lat, 0, 2, 1);
`endif
        req = '0;

        wait_idle();
        repeat (2) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
